// File: rtl/counter_stim_driver_if.sv
// Command/status bundle between a host (master) and counter_stim_driver (slave).
interface counter_stim_driver_if #(
   parameter int WIDTH    = 8,
   parameter int HP_WIDTH = 8
) ();
   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd_op;
   logic [WIDTH-1:0]    cmd_data;
   logic [HP_WIDTH-1:0] half_period;
   logic                abort;
   logic                busy;
   logic                done;

   modport master (
      output cmd_valid, cmd_op, cmd_data, half_period, abort,
      input  cmd_ready, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, half_period, abort,
      output cmd_ready, busy, done
   );
endinterface

// File: rtl/counter_stim_driver.sv
// Turns LOAD / COUNT_UP / COUNT_DOWN / SET_ENABLE commands into slow strobes on the counter pins.
// Define COUNTER_STIM_SHADOW_EN to add shadow_cnt, the value the counter is expected to hold.
module counter_stim_driver #(
   parameter int WIDTH    = 8,
   parameter int HP_WIDTH = 8,
   parameter int MIN_HP   = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   counter_stim_driver_if.slave cmd_if,
   output logic                 enable_o,
   output logic                 clk_in_o,
   output logic                 load_o,
   output logic                 up_down_o,
   output logic [WIDTH-1:0]     data_o
`ifdef COUNTER_STIM_SHADOW_EN
   ,
   output logic [WIDTH-1:0]     shadow_cnt
`endif
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_HIGH  = 3'd2;
   localparam logic [2:0] ST_LOW   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_EN   = 2'b11;

   localparam logic [WIDTH-1:0]    ZERO_W  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]    ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [HP_WIDTH-1:0] HP_ZERO = {HP_WIDTH{1'b0}};
   localparam logic [HP_WIDTH-1:0] HP_ONE  = {{(HP_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [HP_WIDTH-1:0] HP_MIN  = HP_WIDTH'(MIN_HP);

   // Short strobes would slip past the counter's 3-stage synchronizers, so clamp upwards.
   function automatic logic [HP_WIDTH-1:0] clamp_hp(input logic [HP_WIDTH-1:0] req);
      if (req < HP_MIN) begin
         return HP_MIN;
      end else begin
         return req;
      end
   endfunction

   logic [2:0]          state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [HP_WIDTH-1:0] hp_q, hp_d;
   logic [HP_WIDTH-1:0] timer_q, timer_d;
   logic [WIDTH-1:0]    steps_q, steps_d;
   logic [WIDTH-1:0]    data_q, data_d;
   logic                up_down_q, up_down_d;
   logic                enable_q, enable_d;
   logic                load_q, load_d;
   logic                clk_in_q, clk_in_d;
   logic                busy_q, busy_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;

   logic                accept_s;
   logic                abort_s;
   logic                phase_end_s;
   logic [HP_WIDTH-1:0] hp_req_s;

   assign accept_s    = cmd_if.cmd_valid && ready_q;
   assign abort_s     = cmd_if.abort && (state_q != ST_IDLE);
   assign phase_end_s = (timer_q == HP_ZERO);
   assign hp_req_s    = clamp_hp(cmd_if.half_period);

   // Sequencer next state: command capture, phase timing and step counting.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      hp_d      = hp_q;
      timer_d   = timer_q;
      steps_d   = steps_q;
      data_d    = data_q;
      up_down_d = up_down_q;
      enable_d  = enable_q;
      if (abort_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  op_d    = cmd_if.cmd_op;
                  hp_d    = hp_req_s;
                  timer_d = hp_req_s - HP_ONE;
                  steps_d = cmd_if.cmd_data;
                  case (cmd_if.cmd_op)
                     OP_LOAD: begin
                        data_d   = cmd_if.cmd_data;
                        enable_d = 1'b1;
                        state_d  = ST_SETUP;
                     end
                     OP_UP, OP_DOWN: begin
                        up_down_d = (cmd_if.cmd_op == OP_UP);
                        enable_d  = 1'b1;
                        if (cmd_if.cmd_data == ZERO_W) begin
                           state_d = ST_DONE;
                        end else begin
                           state_d = ST_SETUP;
                        end
                     end
                     OP_EN: begin
                        enable_d = cmd_if.cmd_data[0];
                        state_d  = ST_DONE;
                     end
                     default: begin
                        state_d = ST_IDLE;
                     end
                  endcase
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SETUP: begin
               if (phase_end_s) begin
                  state_d = ST_HIGH;
                  timer_d = hp_q - HP_ONE;
                  if (op_q != OP_LOAD) begin
                     steps_d = steps_q - ONE_W;
                  end else begin
                     steps_d = steps_q;
                  end
               end else begin
                  timer_d = timer_q - HP_ONE;
               end
            end
            ST_HIGH: begin
               if (phase_end_s) begin
                  state_d = ST_LOW;
                  timer_d = hp_q - HP_ONE;
               end else begin
                  timer_d = timer_q - HP_ONE;
               end
            end
            ST_LOW: begin
               if (phase_end_s) begin
                  // A LOAD is a single strobe; a count repeats until no steps remain.
                  if ((op_q == OP_LOAD) || (steps_q == ZERO_W)) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_HIGH;
                     timer_d = hp_q - HP_ONE;
                     steps_d = steps_q - ONE_W;
                  end
               end else begin
                  timer_d = timer_q - HP_ONE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode from the next state so every pin and status flag leaves a flop.
   always_comb begin
      busy_d   = (state_d != ST_IDLE);
      ready_d  = (state_d == ST_IDLE);
      done_d   = (state_d == ST_DONE);
      load_d   = (state_d == ST_HIGH) && (op_d == OP_LOAD);
      clk_in_d = (state_d == ST_HIGH) && (op_d != OP_LOAD);
   end

   // State, command context and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_LOAD;
         hp_q      <= HP_MIN;
         timer_q   <= HP_ZERO;
         steps_q   <= ZERO_W;
         data_q    <= ZERO_W;
         up_down_q <= 1'b0;
         enable_q  <= 1'b0;
         load_q    <= 1'b0;
         clk_in_q  <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         hp_q      <= hp_d;
         timer_q   <= timer_d;
         steps_q   <= steps_d;
         data_q    <= data_d;
         up_down_q <= up_down_d;
         enable_q  <= enable_d;
         load_q    <= load_d;
         clk_in_q  <= clk_in_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   assign cmd_if.cmd_ready = ready_q;
   assign cmd_if.busy      = busy_q;
   assign cmd_if.done      = done_q;
   assign enable_o         = enable_q;
   assign clk_in_o         = clk_in_q;
   assign load_o           = load_q;
   assign up_down_o        = up_down_q;
   assign data_o           = data_q;

`ifdef COUNTER_STIM_SHADOW_EN
   logic             strobe_end_s;
   logic [WIDTH-1:0] shadow_q, shadow_d;

   // A strobe only counts once its falling edge is issued; an abort in HIGH cancels it.
   assign strobe_end_s = (state_q == ST_HIGH) && phase_end_s && !cmd_if.abort;

   // Shadow of the receiving counter, updated on each completed strobe.
   always_comb begin
      if (strobe_end_s) begin
         case (op_q)
            OP_LOAD: shadow_d = data_q;
            OP_UP:   shadow_d = shadow_q + ONE_W;
            OP_DOWN: shadow_d = shadow_q - ONE_W;
            default: shadow_d = shadow_q;
         endcase
      end else begin
         shadow_d = shadow_q;
      end
   end

   // Shadow register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= ZERO_W;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign shadow_cnt = shadow_q;
`endif

endmodule

// File: tb/tb_counter_stim_driver.sv
// Directed, table-driven bench for counter_stim_driver; shadow checks run when
// COUNTER_STIM_SHADOW_EN is defined.
module tb_counter_stim_driver;

   typedef struct {
      int op;
      int data;
      int hp;
      int done_k;
      int pulses;
      int first_k;
      int high;
      int exp_data;
      int exp_ud;
      int exp_en;
      int exp_shadow;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable_o, clk_in_o, load_o, up_down_o;
   logic [7:0] data_o;
`ifdef COUNTER_STIM_SHADOW_EN
   logic [7:0] shadow_cnt;
`endif

   int tests = 0;
   int fails = 0;
   vec_t vecs[11];

   always #5 clk = ~clk;

   counter_stim_driver_if #(.WIDTH(8), .HP_WIDTH(8)) cmd_if ();

   counter_stim_driver #(.WIDTH(8), .HP_WIDTH(8), .MIN_HP(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_if    (cmd_if),
      .enable_o  (enable_o),
      .clk_in_o  (clk_in_o),
      .load_o    (load_o),
      .up_down_o (up_down_o),
      .data_o    (data_o)
`ifdef COUNTER_STIM_SHADOW_EN
      ,
      .shadow_cnt(shadow_cnt)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a command for one edge; returns at the sample point just after the accept edge (k=0).
   task automatic send(input int op, input int data, input int hp);
      cmd_if.cmd_valid   = 1'b1;
      cmd_if.cmd_op      = 2'(op);
      cmd_if.cmd_data    = 8'(data);
      cmd_if.half_period = 8'(hp);
      step();
      cmd_if.cmd_valid   = 1'b0;
      cmd_if.half_period = 8'd1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   done_k, pulses, first_k, high, wrong;
      logic prev, strobe, other;
      logic [7:0] d0;
      logic ud0, en0;
      send(v.op, v.data, v.hp);
      d0 = data_o;
      ud0 = up_down_o;
      en0 = enable_o;
      done_k = -1; pulses = 0; first_k = -1; high = 0; wrong = 0; prev = 1'b0;
      for (int k = 0; k < 2000 && done_k < 0; k++) begin
         if (k > 0) step();
         strobe = (v.op == 0) ? load_o : clk_in_o;
         other  = (v.op == 0) ? clk_in_o : load_o;
         if (strobe) begin
            high++;
            if (!prev) begin
               pulses++;
               if (first_k < 0) first_k = k;
            end
         end
         if (other) wrong++;
         prev = strobe;
         if (cmd_if.done) done_k = k;
      end
      check($sformatf("v%0d done_latency", idx), done_k, v.done_k);
      check($sformatf("v%0d strobe_pulses", idx), pulses, v.pulses);
      check($sformatf("v%0d first_strobe", idx), first_k, v.first_k);
      check($sformatf("v%0d strobe_high_cycles", idx), high, v.high);
      check($sformatf("v%0d other_strobe", idx), wrong, 0);
      check($sformatf("v%0d data_o", idx), int'(d0), v.exp_data);
      check($sformatf("v%0d up_down_o", idx), int'(ud0), v.exp_ud);
      check($sformatf("v%0d enable_o", idx), int'(en0), v.exp_en);
      step();
      check($sformatf("v%0d ready_after_done", idx),
            int'({cmd_if.cmd_ready, cmd_if.done, cmd_if.busy}), 4);
`ifdef COUNTER_STIM_SHADOW_EN
      check($sformatf("v%0d shadow_cnt", idx), int'(shadow_cnt), v.exp_shadow);
`endif
   endtask

   initial begin
      int pulses, stray;
      logic prev;

      //            op  data   hp  done pul first high  data  ud en shadow
      vecs[0]  = '{0, 8'hA5, 4,  12,  1,  4,   4,  8'hA5, 0, 1, 8'hA5};
      vecs[1]  = '{1, 3,     1,  21,  3,  3,   9,  8'hA5, 1, 1, 8'hA8};
      vecs[2]  = '{2, 0,     5,  0,   0,  -1,  0,  8'hA5, 0, 1, 8'hA8};
      vecs[3]  = '{3, 8'h00, 3,  0,   0,  -1,  0,  8'hA5, 0, 0, 8'hA8};
      vecs[4]  = '{0, 8'hFE, 3,  9,   1,  3,   3,  8'hFE, 0, 1, 8'hFE};
      vecs[5]  = '{1, 3,     3,  21,  3,  3,   9,  8'hFE, 1, 1, 8'h01};
      vecs[6]  = '{0, 8'h00, 0,  9,   1,  3,   3,  8'h00, 1, 1, 8'h00};
      vecs[7]  = '{2, 1,     6,  18,  1,  6,   6,  8'h00, 0, 1, 8'hFF};
      vecs[8]  = '{3, 8'hFE, 0,  0,   0,  -1,  0,  8'h00, 0, 0, 8'hFF};
      vecs[9]  = '{1, 2,     4,  20,  2,  4,   8,  8'h00, 1, 1, 8'h01};
      vecs[10] = '{1, 255,   3,  1533, 255, 3, 765, 8'h00, 1, 1, 8'h00};

      cmd_if.cmd_valid   = 1'b0;
      cmd_if.cmd_op      = 2'b00;
      cmd_if.cmd_data    = 8'h00;
      cmd_if.half_period = 8'd0;
      cmd_if.abort       = 1'b0;

      // Reset state, both while held and after release.
      repeat (3) step();
      check("in_reset pins", int'({enable_o, clk_in_o, load_o, up_down_o, data_o}), 0);
      check("in_reset status", int'({cmd_if.cmd_ready, cmd_if.busy, cmd_if.done}), 4);
      rst_n = 1'b1;
      repeat (2) step();
      check("idle pins", int'({enable_o, clk_in_o, load_o, up_down_o, data_o}), 0);
      check("idle status", int'({cmd_if.cmd_ready, cmd_if.busy, cmd_if.done}), 4);
`ifdef COUNTER_STIM_SHADOW_EN
      check("idle shadow_cnt", int'(shadow_cnt), 0);
`endif

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // COUNT_UP 5 aborted in the HIGH phase of pulse 2; a LOAD offered while busy is dropped.
      send(1, 5, 3);
      pulses = 0; prev = 1'b0; stray = 0;
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) step();
         if (k == 1) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_op    = 2'b00;
            cmd_if.cmd_data  = 8'h77;
         end
         if (k == 2) cmd_if.cmd_valid = 1'b0;
         if (clk_in_o && !prev) pulses++;
         prev = clk_in_o;
         if (load_o || cmd_if.done) stray++;
      end
      check("abort pulses_before", pulses, 2);
      check("abort clk_in_at_abort", int'(clk_in_o), 1);
      cmd_if.abort = 1'b1;
      step();
      cmd_if.abort = 1'b0;
      check("abort clk_in_next", int'(clk_in_o), 0);
      check("abort status_next", int'({cmd_if.cmd_ready, cmd_if.busy, cmd_if.done}), 4);
      for (int k = 0; k < 8; k++) begin
         step();
         if (clk_in_o || load_o || cmd_if.done || cmd_if.busy) stray++;
      end
      check("abort no_done_no_strobe", stray, 0);
      check("abort pins_kept", int'({enable_o, up_down_o, data_o}), 10'h300);
`ifdef COUNTER_STIM_SHADOW_EN
      check("abort shadow_cnt", int'(shadow_cnt), 8'h01);
`endif

      // abort while idle changes nothing.
      cmd_if.abort = 1'b1;
      repeat (3) step();
      cmd_if.abort = 1'b0;
      check("idle_abort status", int'({cmd_if.cmd_ready, cmd_if.busy, cmd_if.done}), 4);
      check("idle_abort pins", int'({enable_o, up_down_o, data_o}), 10'h300);

      // Asynchronous reset in the middle of a LOAD strobe.
      send(0, 8'h3C, 3);
      repeat (4) step();
      check("midreset load_high", int'({load_o, data_o}), 9'h13C);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset pins", int'({enable_o, clk_in_o, load_o, up_down_o, data_o}), 0);
      check("midreset status", int'({cmd_if.cmd_ready, cmd_if.busy, cmd_if.done}), 4);
`ifdef COUNTER_STIM_SHADOW_EN
      check("midreset shadow_cnt", int'(shadow_cnt), 0);
`endif
      step();
      rst_n = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
